shift_exec_pipe: RTL and testbench

- Two-stage pipelined shift execution unit for the execute stage. Implements SLL, SRL and SRA.
- Right shifts are turned into left shifts by bit reversal, so one SLL_32bit core serves all three ops.
- Consumes issued shift micro-ops from the issue/operand stage.
- Delivers tagged results to the writeback arbiter through a valid/ready handshake.

---
 rtl/shift_pkg.sv | 39 +++
 rtl/shift_exec_pipe_sll.sv | 19 +
 rtl/shift_exec_pipe.sv | 117 +++++++++++
 tb/tb_shift_exec_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the two-stage shift execution unit.
package shift_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SHW   = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_RSV = 2'b10,
    OP_SRA = 2'b11
  } shift_op_e;

  // Stage-1 payload: the operand is already bit-reversed for right shifts.
  typedef struct packed {
    shift_op_e        op;
    logic             sign;
    logic [SHW-1:0]   shamt;
    logic [XLEN-1:0]  opnd;
  } s1_payload_t;

  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

  // Top shamt bits set when the shifted-out value was negative.
  function automatic logic [XLEN-1:0] sra_fill_mask(input logic [SHW-1:0] shamt,
                                                    input logic           sign);
    logic [XLEN-1:0] ones;
    ones = '1;
    return sign ? ~(ones >> shamt) : '0;
  endfunction

endpackage

// File: rtl/shift_exec_pipe_sll.sv
// SLL_32bit: combinational 32-bit logarithmic left shifter, shared by all shift ops.
module SLL_32bit (
  input  logic [31:0] a_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] y_o
);

  logic [31:0] st0, st1, st2, st3, st4;

  // One mux level per shamt bit, smallest distance first.
  assign st0 = shamt_i[0] ? {a_i[30:0], 1'b0}  : a_i;
  assign st1 = shamt_i[1] ? {st0[29:0], 2'b0}  : st0;
  assign st2 = shamt_i[2] ? {st1[27:0], 4'b0}  : st1;
  assign st3 = shamt_i[3] ? {st2[23:0], 8'b0}  : st2;
  assign st4 = shamt_i[4] ? {st3[15:0], 16'b0} : st3;

  assign y_o = st4;

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage SLL/SRL/SRA execution unit; right shifts run through the left
// shifter by reversing bits on the way in and out.
module shift_exec_pipe
  import shift_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [SHW-1:0]    shamt_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic [TAG_W-1:0]  tag_o
);

  logic              s1_valid_q, s1_valid_d;
  s1_payload_t       s1_q, s1_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

  logic              s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]   s2_result_q, s2_result_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

  logic              s2_adv, s1_adv;
  shift_op_e         in_op;
  logic              in_is_right;
  logic [XLEN-1:0]   core_y;
  logic [XLEN-1:0]   post_res;

  assign in_op       = shift_op_e'(op_i);
  assign in_is_right = (in_op == OP_SRL) || (in_op == OP_SRA);

  // Each stage may move when its successor is empty or draining.
  assign s2_adv     = !s2_valid_q || out_ready_i;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign in_ready_o = s1_adv;

  SLL_32bit u_sll (
    .a_i     (s1_q.opnd),
    .shamt_i (s1_q.shamt),
    .y_o     (core_y)
  );

  // Undo the input reversal for right shifts and add sign fill for SRA.
  always_comb begin
    post_res = core_y;
    unique case (s1_q.op)
      OP_SRL:  post_res = bit_reverse(core_y);
      OP_SRA:  post_res = bit_reverse(core_y) | sra_fill_mask(s1_q.shamt, s1_q.sign);
      default: post_res = core_y;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_tag_d    = s2_tag_q;

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = post_res;
        s2_tag_d    = s1_tag_q;
      end
    end

    if (s1_adv) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_d.op    = in_op;
        s1_d.sign  = a_i[XLEN-1] & (in_op == OP_SRA);
        s1_d.shamt = shamt_i;
        s1_d.opnd  = in_is_right ? bit_reverse(a_i) : a_i;
        s1_tag_d   = tag_i;
      end
    end

    // Flush kills everything in flight, including an op offered this cycle.
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign result_o    = s2_result_q;
  assign tag_o       = s2_tag_q;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Directed and randomized bench for shift_exec_pipe with an arithmetic scoreboard.
module tb_shift_exec_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [4:0]  tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  tag_out;

  shift_exec_pipe #(.TAG_W(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .a_i         (a),
    .shamt_i     (shamt),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .tag_o       (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  logic        last_acc;
  logic        last_fire;
  logic [31:0] last_res;
  logic [4:0]  last_tag;
  logic        hold_chk = 1'b0;
  logic [31:0] hold_res;
  logic [4:0]  hold_tag;
  logic        saw_not_ready;

  // Reference behaviour straight from the shift definitions.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] v,
                                        input logic [4:0] s);
    case (o)
      2'b01:   return v >> s;
      2'b11:   return 32'($signed(v) >>> s);
      default: return v << s;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, update the model just after the rising edge.
  task automatic tick();
    logic acc, fire, r, f;
    exp_t e;
    @(negedge clk);
    r    = rst;
    f    = flush;
    acc  = in_valid & in_ready & !r & !f;
    fire = out_valid & out_ready & !r & !f;
    if (in_valid && !in_ready) saw_not_ready = 1'b1;
    if (hold_chk && !r) begin
      chk("stall_result", result, hold_res);
      chk("stall_tag", 32'(tag_out), 32'(hold_tag));
    end
    hold_chk = out_valid & !out_ready & !r & !f;
    hold_res = result;
    hold_tag = tag_out;
    if (fire) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        chk("sb_result", result, sb[0].res);
        chk("sb_tag", 32'(tag_out), 32'(sb[0].tag));
        void'(sb.pop_front());
      end
      last_res = result;
      last_tag = tag_out;
      n_out++;
    end
    e.res = model(op, a, shamt);
    e.tag = tag;
    @(posedge clk);
    #1;
    last_acc  = acc;
    last_fire = fire;
    if (r || f) begin
      sb.delete();
      hold_chk = 1'b0;
    end else if (acc) begin
      sb.push_back(e);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s,
                       input logic [4:0] t);
    int n;
    op = o; a = v; shamt = s; tag = t; in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    chk("issue_accepted", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [1:0] o, input logic [31:0] v,
                         input logic [4:0] s, input logic [4:0] t, input logic [31:0] exp);
    int n;
    out_ready = 1'b1;
    issue(o, v, s, t);
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_fire && n < 10);
    chk({name, "_latency"}, 32'(n), 32'd2);
    chk({name, "_result"}, last_res, exp);
    chk({name, "_tag"}, 32'(last_tag), 32'(t));
  endtask

  initial begin
    int base;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'b00; a = '0; shamt = '0; tag = '0;
    saw_not_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", 32'(tag_out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_one("sll31",   2'b00, 32'h0000_0001, 5'd31, 5'd1,  32'h8000_0000);
    run_one("sll4",    2'b00, 32'h1234_5678, 5'd4,  5'd2,  32'h2345_6780);
    run_one("srl4",    2'b01, 32'h8000_0000, 5'd4,  5'd3,  32'h0800_0000);
    run_one("sra4n",   2'b11, 32'h8000_0000, 5'd4,  5'd4,  32'hF800_0000);
    run_one("sra4p",   2'b11, 32'h7FFF_FFF0, 5'd4,  5'd5,  32'h07FF_FFFF);
    run_one("sra31",   2'b11, 32'h8000_0001, 5'd31, 5'd6,  32'hFFFF_FFFF);
    run_one("sll0",    2'b00, 32'hDEAD_BEEF, 5'd0,  5'd7,  32'hDEAD_BEEF);
    run_one("srl0",    2'b01, 32'hDEAD_BEEF, 5'd0,  5'd8,  32'hDEAD_BEEF);
    run_one("sra0",    2'b11, 32'hDEAD_BEEF, 5'd0,  5'd9,  32'hDEAD_BEEF);
    run_one("rsv3",    2'b10, 32'h0000_0001, 5'd3,  5'd10, 32'h0000_0008);

    // Four back-to-back ops, downstream stalls for three cycles starting at cycle 2.
    base = n_out;
    saw_not_ready = 1'b0;
    begin
      int issued = 0;
      for (int c = 0; c < 12 && issued < 4; c++) begin
        out_ready = (c >= 2 && c < 5) ? 1'b0 : 1'b1;
        in_valid  = 1'b1;
        op = 2'(issued % 4); a = 32'hF0F0_1234 + 32'(issued); shamt = 5'(issued * 3 + 1);
        tag = 5'(20 + issued);
        tick();
        if (last_acc) issued++;
      end
      in_valid = 1'b0;
      chk("b2b_all_issued", 32'(issued), 32'd4);
    end
    chk("b2b_in_ready_fell", 32'(saw_not_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("b2b_count", 32'(n_out - base), 32'd4);

    // Flush with both stages full and another op offered.
    out_ready = 1'b0;
    issue(2'b00, 32'h1111_1111, 5'd1, 5'd11);
    issue(2'b01, 32'h2222_2222, 5'd2, 5'd12);
    in_valid = 1'b1; op = 2'b11; a = 32'h8765_4321; shamt = 5'd5; tag = 5'd13;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    base = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("flush_nothing_out", 32'(n_out - base), 32'd0);

    // Flush on an empty pipe drops the op offered in that cycle.
    in_valid = 1'b1; op = 2'b00; a = 32'h5; shamt = 5'd1; tag = 5'd14;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("flush_drop_new", 32'(n_out - base), 32'd0);
    run_one("post_flush", 2'b01, 32'hC000_0000, 5'd30, 5'd15, 32'h0000_0003);

    // Reset while full and stalled.
    out_ready = 1'b0;
    issue(2'b00, 32'hAAAA_5555, 5'd8, 5'd16);
    issue(2'b11, 32'h9000_0000, 5'd2, 5'd17);
    in_valid = 1'b1; op = 2'b01; a = 32'hFFFF_0000; shamt = 5'd4; tag = 5'd18;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_tag", 32'(tag_out), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    base = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_no_stale", 32'(n_out - base), 32'd0);

    // Randomized traffic with random backpressure and occasional flushes.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      op        = 2'($urandom_range(3));
      case ($urandom_range(3))
        0:       a = 32'h8000_0000 | 32'($urandom_range(255));
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      shamt = 5'($urandom_range(31));
      tag   = 5'($urandom_range(31));
      flush = ($urandom_range(49) == 0);
      if (flush) out_ready = 1'b0;
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) tick();
    chk("rand_drained", 32'(sb.size()), 32'd0);
    chk("rand_out_idle", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
